alu_share_ctrl: RTL and testbench

//  Two-requester round-robin controller that shares the single combinational 16-bit ALU
//  (opc 0 add, 1 sub, 2 set-less-than, 3 or, 4 and, 5 shift-left A<<B).

---
 rtl/alu_share_if.sv | 56 +++++
 rtl/alu_share_ctrl.sv | 175 +++++++++++++++++
 tb/tb_alu_share_ctrl.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_if.sv
// alu_share_if: bundle of the request, ALU and response channels of alu_share_ctrl.
//
// Parameters
//   W      operand/result width
//   OPC_W  opcode width
//
// Signals
//   req_valid/req_ready   per-requester handshake, bit i = requester i
//   req_a/req_b/req_opc   packed operands/opcode, requester i in slice [i*W +: W]
//   alu_inpA/B, alu_opc   controller -> shared ALU
//   alu_res               shared ALU -> controller (combinational)
//   rsp_valid/rsp_ready   response handshake
//   rsp_id/rsp_res/rsp_err response payload
//
// Modports
//   master  requesters, ALU and response consumer (the environment)
//   slave   the controller itself
interface alu_share_if #(
    parameter int unsigned W     = 16,
    parameter int unsigned OPC_W = 4
);
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [2*W-1:0]     req_a;
    logic [2*W-1:0]     req_b;
    logic [2*OPC_W-1:0] req_opc;

    logic [W-1:0]       alu_inpA;
    logic [W-1:0]       alu_inpB;
    logic [OPC_W-1:0]   alu_opc;
    logic [W-1:0]       alu_res;

    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    logic [W-1:0]       rsp_res;
    logic               rsp_err;

    modport master (
        output req_valid, req_a, req_b, req_opc,
        input  req_ready,
        input  alu_inpA, alu_inpB, alu_opc,
        output alu_res,
        input  rsp_valid, rsp_id, rsp_res, rsp_err,
        output rsp_ready
    );

    modport slave (
        input  req_valid, req_a, req_b, req_opc,
        output req_ready,
        output alu_inpA, alu_inpB, alu_opc,
        input  alu_res,
        output rsp_valid, rsp_id, rsp_res, rsp_err,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin controller that lets two requesters share one external
// combinational ALU (opc 0 add, 1 sub, 2 slt, 3 or, 4 and, 5 shl). A granted request has its
// operands registered, is executed on the ALU for one cycle and the result is returned on a
// valid/ready response channel tagged with the requester id.
//
// Ports
//   clk   clock, rising edge
//   rst   synchronous active-high reset; drops any operation in flight
//   bus   alu_share_if.slave: request, ALU and response channels
//   busy  high whenever the controller is not idle
//
// Build option
//   MUL_SEQ_EN  when defined, opc 6 is a W-step shift-add multiply (low W bits of a*b) run on
//               the shared ALU; when undefined, opc 6 is an illegal opcode like 7..15.
module alu_share_ctrl #(
    parameter int unsigned W     = 16,
    parameter int unsigned OPC_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    alu_share_if.slave  bus,
    output logic        busy
);

    localparam logic [OPC_W-1:0] OpcMax = OPC_W'(5);  // highest opcode the ALU implements
`ifdef MUL_SEQ_EN
    localparam logic [OPC_W-1:0] OpcMul = OPC_W'(6);
    localparam int unsigned      CntW   = (W > 1) ? $clog2(W) : 1;
    localparam logic [CntW-1:0]  StepLast = CntW'(W - 1);
`endif

    typedef enum logic [1:0] {StIdle, StExec, StResp, StMul} state_e;

    state_e           state_q, state_d;
    logic [W-1:0]     a_q, a_d;      // operand A; multiplicand while multiplying
    logic [W-1:0]     b_q, b_d;      // operand B; multiplier while multiplying
    logic [OPC_W-1:0] opc_q, opc_d;
    logic             id_q, id_d;
    logic             ptr_q, ptr_d;  // requester favoured when both are valid
    logic [W-1:0]     res_q, res_d;
    logic             err_q, err_d;
    logic             gnt_id;
`ifdef MUL_SEQ_EN
    logic [W-1:0]     acc_q, acc_d;
    logic [CntW-1:0]  step_q, step_d;
`endif

    // Response payload comes straight from registers so it holds steady under backpressure.
    assign bus.rsp_id  = id_q;
    assign bus.rsp_res = res_q;
    assign bus.rsp_err = err_q;

    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        opc_d         = opc_q;
        id_d          = id_q;
        ptr_d         = ptr_q;
        res_d         = res_q;
        err_d         = err_q;
`ifdef MUL_SEQ_EN
        acc_d         = acc_q;
        step_d        = step_q;
`endif
        gnt_id        = 1'b0;
        bus.req_ready = 2'b00;
        bus.alu_inpA  = '0;
        bus.alu_inpB  = '0;
        bus.alu_opc   = '0;
        bus.rsp_valid = 1'b0;
        busy          = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (|bus.req_valid) begin
                    // Contention goes to the pointer; otherwise the sole valid requester wins.
                    gnt_id        = (&bus.req_valid) ? ptr_q : bus.req_valid[1];
                    bus.req_ready = gnt_id ? 2'b10 : 2'b01;
                    a_d           = gnt_id ? bus.req_a[2*W-1:W] : bus.req_a[W-1:0];
                    b_d           = gnt_id ? bus.req_b[2*W-1:W] : bus.req_b[W-1:0];
                    opc_d         = gnt_id ? bus.req_opc[2*OPC_W-1:OPC_W]
                                           : bus.req_opc[OPC_W-1:0];
                    id_d          = gnt_id;
                    ptr_d         = ~gnt_id;
                    state_d       = StExec;
`ifdef MUL_SEQ_EN
                    if (opc_d == OpcMul) begin
                        acc_d   = '0;
                        step_d  = '0;
                        state_d = StMul;
                    end
`endif
                end
            end

            StExec: begin
                bus.alu_inpA = a_q;
                bus.alu_inpB = b_q;
                bus.alu_opc  = opc_q;
                if (opc_q <= OpcMax) begin
                    res_d = bus.alu_res;
                    err_d = 1'b0;
                end else begin
                    res_d = '0;
                    err_d = 1'b1;
                end
                state_d = StResp;
            end

            StResp: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end

`ifdef MUL_SEQ_EN
            StMul: begin
                // One shift-add step per cycle: ALU adds the shifted multiplicand to acc.
                bus.alu_inpA = acc_q;
                bus.alu_inpB = a_q;
                bus.alu_opc  = '0;
                if (b_q[0]) begin
                    acc_d = bus.alu_res;
                end
                a_d    = a_q << 1;
                b_d    = b_q >> 1;
                step_d = step_q + 1'b1;
                if (step_q == StepLast) begin
                    // Take the accumulator including this final step's contribution.
                    res_d   = b_q[0] ? bus.alu_res : acc_q;
                    err_d   = 1'b0;
                    state_d = StResp;
                end
            end
`endif

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            opc_q   <= '0;
            id_q    <= 1'b0;
            ptr_q   <= 1'b0;
            res_q   <= '0;
            err_q   <= 1'b0;
`ifdef MUL_SEQ_EN
            acc_q   <= '0;
            step_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            opc_q   <= opc_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            res_q   <= res_d;
            err_q   <= err_d;
`ifdef MUL_SEQ_EN
            acc_q   <= acc_d;
            step_q  <= step_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: provides the external ALU, drives requests, and checks every
// response against a scoreboard filled at grant time.
module tb_alu_share_ctrl;

    localparam int unsigned W     = 16;
    localparam int unsigned OPC_W = 4;
`ifdef MUL_SEQ_EN
    localparam bit MulEn = 1'b1;
`else
    localparam bit MulEn = 1'b0;
`endif

    typedef struct {
        logic         id;
        logic [W-1:0] res;
        logic         err;
        int           lat;
        int           gcyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    alu_share_if #(.W(W), .OPC_W(OPC_W)) bus ();

    alu_share_ctrl #(.W(W), .OPC_W(OPC_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
    );

    always #5 clk = ~clk;

    // External ALU the controller shares.
    always_comb begin
        bus.alu_res = '0;
        case (bus.alu_opc)
            4'd0: bus.alu_res = bus.alu_inpA + bus.alu_inpB;
            4'd1: bus.alu_res = bus.alu_inpA - bus.alu_inpB;
            4'd2: bus.alu_res = (bus.alu_inpA < bus.alu_inpB) ? 16'd1 : 16'd0;
            4'd3: bus.alu_res = bus.alu_inpA | bus.alu_inpB;
            4'd4: bus.alu_res = bus.alu_inpA & bus.alu_inpB;
            4'd5: bus.alu_res = bus.alu_inpA << bus.alu_inpB;
            default: bus.alu_res = '0;
        endcase
    end

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   last_gnt = 0;
    int   last_hs = 0;
    bit   in_rsp = 1'b0;
    exp_t sb[$];
    logic gnt_log[$];
    exp_t e_new;
    exp_t e_head;
    logic gid;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic exp_t exp_of(input logic id, input logic [W-1:0] a,
                                    input logic [W-1:0] b, input logic [OPC_W-1:0] opc,
                                    input int gcyc);
        exp_t             e;
        logic [2*W-1:0]   p;
        e.id   = id;
        e.gcyc = gcyc;
        e.lat  = 2;
        e.err  = 1'b0;
        e.res  = '0;
        case (opc)
            4'd0: e.res = a + b;
            4'd1: e.res = a - b;
            4'd2: e.res = (a < b) ? 16'd1 : 16'd0;
            4'd3: e.res = a | b;
            4'd4: e.res = a & b;
            4'd5: e.res = a << b;
            4'd6: begin
                if (MulEn) begin
                    p     = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                    e.res = p[W-1:0];
                    e.lat = W + 1;
                end else begin
                    e.err = 1'b1;
                end
            end
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            sb.delete();
            in_rsp = 1'b0;
        end else begin
            if (|bus.req_ready) begin
                check_eq("ready_onehot", 64'($countones(bus.req_ready)), 1);
                check_eq("ready_without_valid", bus.req_ready & ~bus.req_valid, 0);
                gid = bus.req_ready[1];
                gnt_log.push_back(gid);
                last_gnt = cyc;
                e_new = exp_of(gid, gid ? bus.req_a[2*W-1:W] : bus.req_a[W-1:0],
                               gid ? bus.req_b[2*W-1:W] : bus.req_b[W-1:0],
                               gid ? bus.req_opc[2*OPC_W-1:OPC_W] : bus.req_opc[OPC_W-1:0],
                               cyc);
                sb.push_back(e_new);
            end
            if (busy) begin
                check_eq("ready_while_busy", bus.req_ready, 0);
            end else begin
                check_eq("alu_idle_zero", {bus.alu_inpA, bus.alu_inpB, bus.alu_opc}, 0);
                check_eq("rsp_valid_idle", bus.rsp_valid, 0);
            end
            if (bus.rsp_valid) begin
                if (sb.size() == 0) begin
                    check_eq("rsp_unexpected", bus.rsp_valid, 0);
                end else begin
                    e_head = sb[0];
                    if (!in_rsp) check_eq("latency", 64'(cyc - e_head.gcyc), 64'(e_head.lat));
                    check_eq("rsp_id", bus.rsp_id, e_head.id);
                    check_eq("rsp_res", bus.rsp_res, e_head.res);
                    check_eq("rsp_err", bus.rsp_err, e_head.err);
                    if (bus.rsp_ready) begin
                        void'(sb.pop_front());
                        last_hs = cyc;
                    end
                end
            end
            in_rsp = bus.rsp_valid && !bus.rsp_ready;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [OPC_W-1:0] opc);
        if (id) begin
            bus.req_a[2*W-1:W]           = a;
            bus.req_b[2*W-1:W]           = b;
            bus.req_opc[2*OPC_W-1:OPC_W] = opc;
        end else begin
            bus.req_a[W-1:0]     = a;
            bus.req_b[W-1:0]     = b;
            bus.req_opc[OPC_W-1:0] = opc;
        end
        bus.req_valid[id] = 1'b1;
    endtask

    // Raise a request and hold it until granted; returns just after the grant edge (DUT busy).
    task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [OPC_W-1:0] opc);
        bit got = 1'b0;
        set_req(id, a, b, opc);
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (bus.req_ready[id]) got = 1'b1;
        end
        if (!got) check_eq("grant_timeout", bus.req_ready[id], 1);
        tick();
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((sb.size() != 0 || busy) && k < 100) begin
            tick();
            k++;
        end
        if (k >= 100) check_eq("idle_timeout", busy, 0);
    endtask

    task automatic wait_rsp();
        int k = 0;
        while (!bus.rsp_valid && k < 100) begin
            tick();
            k++;
        end
        if (k >= 100) check_eq("rsp_timeout", bus.rsp_valid, 1);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_rsp_valid", bus.rsp_valid, 0);
        check_eq("rst_rsp_id", bus.rsp_id, 0);
        check_eq("rst_rsp_res", bus.rsp_res, 0);
        check_eq("rst_rsp_err", bus.rsp_err, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_alu", {bus.alu_inpA, bus.alu_inpB, bus.alu_opc}, 0);
        check_eq("rst_req_ready", bus.req_ready, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_opc   = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) tick();
        check_reset_outputs();
        rst = 1'b0;
        tick();

        // Basic ops from requester 0: expect 10, 6, 0, 10, 0, 32.
        for (int op = 0; op < 6; op++) begin
            issue(1'b0, 16'd8, 16'd2, OPC_W'(op));
            wait_idle();
        end

        // Both requesters valid from reset: grants alternate 0,1,0,1.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        gnt_log.delete();
        set_req(1'b0, 16'd5, 16'd3, 4'd0);
        set_req(1'b1, 16'd5, 16'd3, 4'd1);
        for (int k = 0; k < 50 && gnt_log.size() < 4; k++) tick();
        bus.req_valid = 2'b00;
        wait_idle();
        check_eq("rr_count", 64'(gnt_log.size()), 4);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++) begin
            check_eq("rr_order", gnt_log[i], 64'(i % 2));
        end

        // Backpressure: payload holds, no grant until the cycle after the handshake.
        bus.rsp_ready = 1'b0;
        issue(1'b1, 16'h1234, 16'h0F0F, 4'd3);
        wait_rsp();
        set_req(1'b0, 16'd3, 16'd4, 4'd0);
        repeat (5) tick();
        bus.rsp_ready = 1'b1;
        issue(1'b0, 16'd3, 16'd4, 4'd0);
        check_eq("gnt_after_hs", 64'(last_gnt - last_hs), 1);
        wait_idle();

        // Illegal opcode and wrapping subtract.
        issue(1'b0, 16'd1, 16'd1, 4'd9);
        wait_idle();
        issue(1'b0, 16'd0, 16'd1, 4'd1);
        wait_idle();
        issue(1'b1, 16'd1, 16'd1, 4'd15);
        wait_idle();

        // Reset during EXEC drops the op; next request proceeds normally.
        issue(1'b1, 16'd5, 16'd5, 4'd0);
        rst = 1'b1;
        tick();
        check_reset_outputs();
        rst = 1'b0;
        issue(1'b0, 16'd9, 16'd1, 4'd1);
        wait_idle();

        // Reset during RESP.
        bus.rsp_ready = 1'b0;
        issue(1'b1, 16'h00FF, 16'h0F00, 4'd3);
        wait_rsp();
        rst = 1'b1;
        tick();
        check_reset_outputs();
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        issue(1'b1, 16'd2, 16'd3, 4'd0);
        wait_idle();

        // Opcode 6: multiply when enabled, illegal otherwise.
        issue(1'b0, 16'd300, 16'd7, 4'd6);
        wait_idle();
        issue(1'b1, 16'h0100, 16'h0100, 4'd6);
        wait_idle();
        issue(1'b0, 16'hFFFF, 16'h0003, 4'd6);
        wait_idle();

        check_eq("sb_drained", 64'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
